// File: rtl/ddr2_port_arb_pkg.sv
// Shared types for the DDR2 controller port arbiter.
// State encoding plus Wishbone cycle-type / burst-type constants.
package ddr2_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

endpackage

// File: rtl/ddr2_port_arb_if.sv
// Bundle of the NM Wishbone master ports and the single DDR2 controller port.
// "slave" is the arbiter's view; "master" is the requester/controller side.
interface ddr2_port_arb_if #(
    parameter int NM = 3,
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    logic [NM-1:0]    m_cyc_i;
    logic [NM-1:0]    m_stb_i;
    logic [NM-1:0]    m_we_i;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*SW-1:0] m_sel_i;
    logic [NM*3-1:0]  m_cti_i;
    logic [NM*2-1:0]  m_bte_i;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;

    logic             s_cyc_o;
    logic             s_stb_o;
    logic             s_we_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic [SW-1:0]    s_sel_o;
    logic [2:0]       s_cti_o;
    logic [1:0]       s_bte_o;
    logic [DW-1:0]    s_dat_i;
    logic             s_ack_i;
    logic             s_err_i;

    logic [NM-1:0]    gnt_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i,
        input  m_sel_i, m_cti_i, m_bte_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        output s_sel_o, s_cti_o, s_bte_o,
        input  s_dat_i, s_ack_i, s_err_i,
        output gnt_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i,
        output m_sel_i, m_cti_i, m_bte_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        input  s_sel_o, s_cti_o, s_bte_o,
        output s_dat_i, s_ack_i, s_err_i,
        input  gnt_o
    );

endinterface

// File: rtl/ddr2_port_arb_rr_pick.sv
// Round-robin first-set search: scans req upward from ptr, wrapping,
// and returns the one-hot position of the first requester found.
module rr_pick #(
    parameter int NM = 3,
    parameter int PW = 2
) (
    input  logic [NM-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [NM-1:0] gnt
);

    // Walk NM positions starting at ptr; the first set bit wins.
    always_comb begin
        int idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NM; k++) begin
            idx = (int'(ptr) + k) % NM;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr2_port_arb.sv
// Round-robin arbiter sharing one DDR2 controller Wishbone port among NM masters.
// Optional stall watchdog enabled by defining DDR2_PORT_ARB_TIMEOUT_EN.
module ddr2_port_arb
    import ddr2_arb_pkg::*;
#(
    parameter int NM      = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    ddr2_port_arb_if.slave bus
);

    localparam int SW = DW / 8;
    localparam int PW = (NM > 1) ? $clog2(NM) : 1;

    arb_state_e    state;
    arb_state_e    state_d;
    logic [NM-1:0] gnt;
    logic [NM-1:0] gnt_d;
    logic [NM-1:0] pick;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] gidx;
    logic [PW-1:0] ptr_nxt;
    logic          owned;
    logic          timeout;

    rr_pick #(
        .NM (NM),
        .PW (PW)
    ) u_pick (
        .req (bus.m_cyc_i),
        .ptr (ptr),
        .gnt (pick)
    );

    // Index of the currently granted master, derived from the one-hot grant.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NM; i++) begin
            if (gnt[i]) gidx = PW'(i);
        end
    end

    assign owned   = (state == OWNED);
    assign ptr_nxt = (gidx == PW'(NM - 1)) ? '0 : gidx + 1'b1;

`ifdef DDR2_PORT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          stall;

    // Stall is judged on the raw strobe so forcing s_stb_o low cannot feed back.
    assign stall   = owned & bus.m_stb_i[gidx] & ~bus.s_ack_i & ~bus.s_err_i;
    assign timeout = stall & (cnt == CW'(TIMEOUT));

    // Watchdog: counts stalled strobe cycles, clears on any termination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!owned || !stall || timeout) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign unused_cfg = ^32'(TIMEOUT);
`endif

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_d;
            gnt   <= gnt_d;
            ptr   <= ptr_d;
        end
    end

    // Next state: grant on any cyc in IDLE, release when the owner drops cyc.
    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        ptr_d   = ptr;
        unique case (state)
            IDLE: begin
                if (|bus.m_cyc_i) begin
                    state_d = OWNED;
                    gnt_d   = pick;
                end
            end
            OWNED: begin
                if (!bus.m_cyc_i[gidx] || timeout) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_nxt;
                end
            end
        endcase
    end

    // Route the owner onto the controller port and steer its terminations back.
    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.s_cti_o = '0;
        bus.s_bte_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        if (owned) begin
            bus.s_cyc_o = bus.m_cyc_i[gidx] & ~timeout;
            bus.s_stb_o = bus.m_stb_i[gidx] & ~timeout;
            bus.s_we_o  = bus.m_we_i[gidx];
            bus.s_adr_o = bus.m_adr_i[int'(gidx)*AW +: AW];
            bus.s_dat_o = bus.m_dat_i[int'(gidx)*DW +: DW];
            bus.s_sel_o = bus.m_sel_i[int'(gidx)*SW +: SW];
            bus.s_cti_o = bus.m_cti_i[int'(gidx)*3 +: 3];
            bus.s_bte_o = bus.m_bte_i[int'(gidx)*2 +: 2];
            bus.m_ack_o[gidx] = bus.s_ack_i;
            bus.m_err_o[gidx] = bus.s_err_i | timeout;
        end
    end

    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.gnt_o   = gnt;

endmodule

// File: tb/tb_ddr2_port_arb.sv
// Testbench for ddr2_port_arb: vector table, corner sequences, random vs model.
// Honours DDR2_PORT_ARB_TIMEOUT_EN for the stalled-slave scenario.
module tb_ddr2_port_arb;
    import ddr2_arb_pkg::*;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 255;

    logic clk;
    logic rst_n;
    int   npass;
    int   ntot;

    ddr2_port_arb_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

    ddr2_port_arb #(
        .NM      (NM),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cyc;
        logic        ack;
        logic        err;
        logic [2:0]  gnt;
        logic        scyc;
        logic [31:0] adr;
        logic [2:0]  mack;
        logic [2:0]  merr;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ntot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end else begin
            npass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_adr_i = {32'h200, 32'h100, 32'h000};
        bus.m_dat_i = '0;
        bus.m_sel_i = '1;
        bus.m_cti_i = '0;
        bus.m_bte_i = '0;
        bus.s_dat_i = '0;
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Random run state and reference model variables.
    logic [NM-1:0]    r_cyc, r_stb, r_we;
    logic [NM*AW-1:0] r_adr;
    logic [NM*DW-1:0] r_dat;
    logic [NM*4-1:0]  r_sel;
    logic [NM*3-1:0]  r_cti;
    logic [NM*2-1:0]  r_bte;
    logic [DW-1:0]    r_sdat;
    logic             r_ack, r_err;
    int               own, rrp;
    logic [NM-1:0]    e_gnt, e_ack, e_err;
    logic [11:0]      e_ctl;
    logic [31:0]      e_adr, e_dat;
    int               errs;
    bit               seen;

    initial begin
        npass = 0;
        ntot  = 0;
        rst_n = 1'b0;
        clear_inputs();

        tbl[0]  = '{3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 32'h000, 3'b000, 3'b000};
        tbl[1]  = '{3'b111, 1'b1, 1'b0, 3'b001, 1'b1, 32'h000, 3'b001, 3'b000};
        tbl[2]  = '{3'b110, 1'b0, 1'b0, 3'b001, 1'b0, 32'h000, 3'b000, 3'b000};
        tbl[3]  = '{3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 32'h000, 3'b000, 3'b000};
        tbl[4]  = '{3'b111, 1'b1, 1'b0, 3'b010, 1'b1, 32'h100, 3'b010, 3'b000};
        tbl[5]  = '{3'b101, 1'b0, 1'b0, 3'b010, 1'b0, 32'h100, 3'b000, 3'b000};
        tbl[6]  = '{3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 32'h000, 3'b000, 3'b000};
        tbl[7]  = '{3'b111, 1'b0, 1'b1, 3'b100, 1'b1, 32'h200, 3'b000, 3'b100};
        tbl[8]  = '{3'b011, 1'b0, 1'b0, 3'b100, 1'b0, 32'h200, 3'b000, 3'b000};
        tbl[9]  = '{3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 32'h000, 3'b000, 3'b000};
        tbl[10] = '{3'b111, 1'b1, 1'b0, 3'b001, 1'b1, 32'h000, 3'b001, 3'b000};
        tbl[11] = '{3'b000, 1'b0, 1'b0, 3'b001, 1'b0, 32'h000, 3'b000, 3'b000};
        tbl[12] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h000, 3'b000, 3'b000};

        // Reset state.
        tick();
        #4;
        chk("rst_gnt", 64'(bus.gnt_o), 64'(0));
        chk("rst_scyc", 64'({bus.s_cyc_o, bus.s_stb_o}), 64'(0));
        chk("rst_ack_err", 64'({bus.m_ack_o, bus.m_err_o}), 64'(0));
        do_reset();

        // Table: three masters from reset, grant order 0,1,2,0.
        for (int v = 0; v < 13; v++) begin
            bus.m_cyc_i = tbl[v].cyc;
            bus.m_stb_i = tbl[v].cyc;
            bus.s_ack_i = tbl[v].ack;
            bus.s_err_i = tbl[v].err;
            #4;
            chk($sformatf("tbl%0d_gnt", v), 64'(bus.gnt_o), 64'(tbl[v].gnt));
            chk($sformatf("tbl%0d_scyc", v), 64'(bus.s_cyc_o), 64'(tbl[v].scyc));
            chk($sformatf("tbl%0d_adr", v), 64'(bus.s_adr_o), 64'(tbl[v].adr));
            chk($sformatf("tbl%0d_ack", v), 64'(bus.m_ack_o), 64'(tbl[v].mack));
            chk($sformatf("tbl%0d_err", v), 64'(bus.m_err_o), 64'(tbl[v].merr));
            tick();
        end

        // Single master 1 write.
        do_reset();
        bus.m_cyc_i = 3'b010;
        bus.m_stb_i = 3'b010;
        bus.m_we_i  = 3'b010;
        bus.m_dat_i = {32'h0, 32'hDEADBEEF, 32'h0};
        #4;
        chk("wr_latency_idle", 64'(bus.s_cyc_o), 64'(0));
        tick();
        bus.s_ack_i = 1'b1;
        #4;
        chk("wr_scyc", 64'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}), 64'(3'b111));
        chk("wr_adr", 64'(bus.s_adr_o), 64'(32'h100));
        chk("wr_dat", 64'(bus.s_dat_o), 64'(32'hDEADBEEF));
        chk("wr_gnt", 64'(bus.gnt_o), 64'(3'b010));
        chk("wr_ack", 64'(bus.m_ack_o), 64'(3'b010));
        bus.s_dat_i = 32'h1234_5678;
        #1;
        chk("rd_broadcast", 64'(bus.m_dat_o), 64'(32'h1234_5678));

        // Master 0 eight-beat incrementing burst with master 2 waiting.
        do_reset();
        bus.m_cyc_i = 3'b101;
        bus.m_stb_i = 3'b101;
        bus.m_cti_i = {CTI_INCR, CTI_CLASSIC, CTI_INCR};
        tick();
        bus.s_ack_i = 1'b1;
        for (int b = 1; b <= 8; b++) begin
            if (b == 8) bus.m_cti_i[2:0] = CTI_EOB;
            #4;
            chk($sformatf("burst_b%0d_gnt", b), 64'(bus.gnt_o), 64'(3'b001));
            chk($sformatf("burst_b%0d_ack", b), 64'(bus.m_ack_o), 64'(3'b001));
            if (b == 8) chk("burst_eob_cti", 64'(bus.s_cti_o), 64'(CTI_EOB));
            tick();
        end
        bus.s_ack_i    = 1'b0;
        bus.m_cyc_i[0] = 1'b0;
        bus.m_stb_i[0] = 1'b0;
        #4;
        chk("burst_release_gnt", 64'(bus.gnt_o), 64'(3'b001));
        tick();
        #4;
        chk("burst_gap_gnt", 64'(bus.gnt_o), 64'(3'b000));
        tick();
        #4;
        chk("burst_next_gnt", 64'(bus.gnt_o), 64'(3'b100));

        // Reset during beat 3 of master 1's burst.
        do_reset();
        bus.m_cyc_i = 3'b001;
        bus.m_stb_i = 3'b001;
        tick();
        bus.m_cyc_i = 3'b000;
        bus.m_stb_i = 3'b000;
        tick();
        bus.m_cyc_i = 3'b010;
        bus.m_stb_i = 3'b010;
        bus.m_cti_i = {CTI_CLASSIC, CTI_INCR, CTI_CLASSIC};
        tick();
        bus.s_ack_i = 1'b1;
        tick();
        tick();
        #2;
        chk("arst_pre_gnt", 64'(bus.gnt_o), 64'(3'b010));
        rst_n = 1'b0;
        #1;
        chk("arst_scyc", 64'({bus.s_cyc_o, bus.s_stb_o}), 64'(0));
        chk("arst_gnt", 64'(bus.gnt_o), 64'(0));
        chk("arst_ack", 64'(bus.m_ack_o), 64'(0));
        tick();
        rst_n = 1'b1;
        bus.m_cyc_i = 3'b111;
        bus.m_stb_i = 3'b111;
        #4;
        chk("arst_release_ack", 64'(bus.m_ack_o), 64'(0));
        tick();
        #4;
        chk("arst_ptr_zero", 64'(bus.gnt_o), 64'(3'b001));

        // Stalled slave.
        do_reset();
        bus.m_cyc_i = 3'b001;
        bus.m_stb_i = 3'b001;
        tick();
`ifdef DDR2_PORT_ARB_TIMEOUT_EN
        seen = 1'b0;
        for (int c = 0; c < TO + 8 && !seen; c++) begin
            #4;
            if (bus.m_err_o == 3'b001) begin
                seen = 1'b1;
                chk("to_scyc_forced", 64'(bus.s_cyc_o), 64'(0));
            end
            tick();
        end
        chk("to_err_seen", 64'(seen), 64'(1));
        #4;
        chk("to_idle_gnt", 64'(bus.gnt_o), 64'(0));
`else
        errs = 0;
        for (int c = 0; c < 1000; c++) begin
            #4;
            if (bus.m_err_o != '0) errs++;
            tick();
        end
        chk("stall_no_err", 64'(errs), 64'(0));
        #4;
        chk("stall_hold_gnt", 64'(bus.gnt_o), 64'(3'b001));
`endif

        // Random stimulus against a round-robin ownership model.
        do_reset();
        own   = -1;
        rrp   = 0;
        r_cyc = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (r_cyc[i]) r_cyc[i] = ($urandom_range(0, 4) != 0);
                else          r_cyc[i] = ($urandom_range(0, 2) == 0);
            end
            r_stb  = 3'($urandom);
            r_we   = 3'($urandom);
            r_adr  = {$urandom, $urandom, $urandom};
            r_dat  = {$urandom, $urandom, $urandom};
            r_sel  = 12'($urandom);
            r_cti  = 9'($urandom);
            r_bte  = 6'($urandom);
            r_sdat = $urandom;
            r_ack  = 1'($urandom);
            r_err  = ($urandom_range(0, 7) == 0);
            bus.m_cyc_i = r_cyc;
            bus.m_stb_i = r_stb;
            bus.m_we_i  = r_we;
            bus.m_adr_i = r_adr;
            bus.m_dat_i = r_dat;
            bus.m_sel_i = r_sel;
            bus.m_cti_i = r_cti;
            bus.m_bte_i = r_bte;
            bus.s_dat_i = r_sdat;
            bus.s_ack_i = r_ack;
            bus.s_err_i = r_err;

            e_gnt = '0;
            e_ack = '0;
            e_err = '0;
            e_ctl = '0;
            e_adr = '0;
            e_dat = '0;
            if (own >= 0) begin
                e_gnt[own] = 1'b1;
                e_ack[own] = r_ack;
                e_err[own] = r_err;
                e_ctl = {r_cyc[own], r_stb[own], r_we[own], r_sel[own*4 +: 4],
                         r_cti[own*3 +: 3], r_bte[own*2 +: 2]};
                e_adr = r_adr[own*32 +: 32];
                e_dat = r_dat[own*32 +: 32];
            end
            #4;
            chk("rnd_gnt", 64'(bus.gnt_o), 64'(e_gnt));
            chk("rnd_ctl", 64'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o,
                                 bus.s_cti_o, bus.s_bte_o}), 64'(e_ctl));
            chk("rnd_adr", 64'(bus.s_adr_o), 64'(e_adr));
            chk("rnd_dat", 64'(bus.s_dat_o), 64'(e_dat));
            chk("rnd_ack", 64'(bus.m_ack_o), 64'(e_ack));
            chk("rnd_err", 64'(bus.m_err_o), 64'(e_err));
            chk("rnd_mdat", 64'(bus.m_dat_o), 64'(r_sdat));
            tick();

            if (own < 0) begin
                for (int k = 0; k < NM && own < 0; k++) begin
                    if (r_cyc[(rrp + k) % NM]) own = (rrp + k) % NM;
                end
            end else if (!r_cyc[own]) begin
                rrp = (own + 1) % NM;
                own = -1;
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/ddr2_port_arb.md
DDR2_PORT_ARB -- requirements
Module: ddr2_port_arb

Interface
REQ-001 SHALL have parameter NM, default 3, number of Wishbone masters sharing the DDR2 controller port.
REQ-002 SHALL have parameter AW, default 32, address width; DW, default 32, data width (SW = DW/8).
REQ-003 SHALL have parameter TIMEOUT, default 255, watchdog limit in cycles (used only with REQ-030).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 m_cyc_i, m_stb_i, m_we_i  in  NM each  per-master Wishbone control; bit i = master i.
REQ-007 m_adr_i  in  NM*AW; m_dat_i  in  NM*DW; m_sel_i  in  NM*SW; m_cti_i  in  NM*3; m_bte_i  in  NM*2; slice i = master i.
REQ-008 m_dat_o  out  DW  read data broadcast to all masters.
REQ-009 m_ack_o, m_err_o  out  NM  per-master termination.
REQ-010 s_cyc_o, s_stb_o, s_we_o  out  1; s_adr_o AW; s_dat_o DW; s_sel_o SW; s_cti_o 3; s_bte_o 2  to DDR2 controller.
REQ-011 s_dat_i  in  DW; s_ack_i, s_err_i  in  1  from DDR2 controller.
REQ-012 gnt_o  out  NM  one-hot current grant (debug/monitor).

Function
REQ-013 FSM SHALL have states IDLE and OWNED only.
REQ-014 In IDLE with any m_cyc_i set, the winner SHALL be the first set bit searching upward from rr_ptr, wrapping from NM-1 to 0; gnt_o registers winner and state moves to OWNED at the next edge.
REQ-015 In IDLE, gnt_o SHALL be 0, s_cyc_o/s_stb_o SHALL be 0, and all m_ack_o/m_err_o SHALL be 0.
REQ-016 In OWNED, s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o/s_cti_o/s_bte_o SHALL be the combinational mux of the granted master's inputs.
REQ-017 In OWNED, m_ack_o/m_err_o of the granted master SHALL equal s_ack_i/s_err_i combinationally; other masters SHALL see 0.
REQ-018 m_dat_o SHALL equal s_dat_i combinationally at all times.
REQ-019 Grant SHALL be held for as long as the granted m_cyc_i stays high, covering Wishbone incrementing/wrap bursts (cti 010) without re-arbitration.
REQ-020 When the granted m_cyc_i is 0 in OWNED, the next edge SHALL return to IDLE and set rr_ptr = (granted index + 1) mod NM.
REQ-021 Minimum gap between consecutive grants SHALL be one IDLE cycle; first-request-to-s_cyc_o latency SHALL be exactly 1 cycle.
REQ-022 Requests from masters not granted SHALL be ignored (no ack/err); they wait with no starvation beyond NM-1 ownership periods.
REQ-023 Simultaneous requests in IDLE SHALL resolve per REQ-014 only; m_stb_i is not considered for arbitration.

Reset
REQ-024 On rst_n low: state = IDLE, gnt_o = 0, rr_ptr = 0, watchdog counter = 0, all s_* control outputs and m_ack_o/m_err_o = 0.
REQ-025 Reset asserted mid-burst SHALL abort immediately; no ack is generated after reset release until a new grant.

Configuration
REQ-030 With macro DDR2_PORT_ARB_TIMEOUT_EN defined: in OWNED, a counter SHALL increment each cycle s_stb_o=1 and s_ack_i=s_err_i=0, clear on ack/err or leaving OWNED.
REQ-031 With the macro, when the counter reaches TIMEOUT the granted master's m_err_o SHALL pulse high one cycle, s_cyc_o/s_stb_o SHALL be forced 0 that cycle, and state SHALL return to IDLE with rr_ptr advanced per REQ-020.
REQ-032 Without the macro, no counter SHALL exist and a stalled slave holds the grant indefinitely.

Structure
REQ-033 Package ddr2_arb_pkg SHALL hold the state enum (IDLE, OWNED) and Wishbone cti/bte constants (CTI_CLASSIC=000, CTI_INCR=010, CTI_EOB=111).
REQ-034 Sub-module rr_pick SHALL implement the round-robin first-set search (NM-bit req, rr_ptr in, one-hot out); everything else stays in ddr2_port_arb.

Verification
REQ-040 Single master 1 writes adr 0x100, data 0xDEADBEEF -> s_cyc_o high 1 cycle after m_cyc_i[1], s_adr_o=0x100, m_ack_o[1]=s_ack_i, gnt_o=3'b010.
REQ-041 Masters 0,1,2 request together from reset -> grant order 0,1,2,0 with one IDLE cycle between each release and next grant.
REQ-042 Master 0 runs 8-beat cti=010 read burst while master 2 requests -> master 2 not granted until master 0 drops m_cyc_i after beat 8 (cti 111).
REQ-043 Slave never acks, macro defined, TIMEOUT=255 -> m_err_o of granted master pulses at cycle 255 of stall, state IDLE next cycle; macro undefined -> no err after 1000 cycles.
REQ-044 rst_n pulsed low during burst beat 3 -> s_cyc_o and gnt_o 0 asynchronously, rr_ptr=0, no further ack to that master.
